// File: rtl/cpu_pkg.sv
// Shared CPU definitions: prefetch queue depth, reset CS:IP and real-mode linear address.
package cpu_pkg;

    localparam int          PQ_DEPTH = 8;
    localparam logic [15:0] RESET_CS = 16'h0000;
    localparam logic [15:0] RESET_IP = 16'h0000;

    // (cs<<4)+ip with no A20 masking; the carry lands in bit 20.
    function automatic logic [31:0] linear(input logic [15:0] cs, input logic [15:0] ip);
        return {12'h000, cs, 4'h0} + {16'h0000, ip};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Byte FIFO holding prefetched code; clear wins over push/pop.
module prefetch_fifo #(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes at CS:IP into a FIFO whenever the bus is idle.
module prefetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH  = PQ_DEPTH,
    parameter  int ADDR_W = 32,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              locked,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] address,
    output logic              rd,
    input  logic [7:0]        i_data,
    input  logic              flush,
    input  logic [15:0]       flush_cs,
    input  logic [15:0]       flush_ip,
    output logic              q_valid,
    output logic [7:0]        q_data,
    output logic [15:0]       q_ip,
    input  logic              q_pop,
    output logic [CW-1:0]     q_count
);

    logic [15:0]   fetch_cs_q, fetch_cs_d;
    logic [15:0]   fetch_ip_q, fetch_ip_d;
    logic [15:0]   head_ip_q,  head_ip_d;
    logic          pending_q,  pending_d;
    logic          drop_q,     drop_d;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          push, pop;

    // Same-cycle pops are deliberately not credited, keeping the full check simple.
    assign occupancy = {1'b0, count} + (CW+1)'(pending_q);
    assign rd        = reset_n && locked && !mem_busy && !flush && (occupancy < (CW+1)'(DEPTH));
    assign push      = pending_q && !drop_q && !flush;
    assign pop       = q_pop && q_valid && locked && !flush;

    always_comb begin
        fetch_cs_d = fetch_cs_q;
        fetch_ip_d = fetch_ip_q;
        head_ip_d  = head_ip_q;
        pending_d  = rd;
        drop_d     = 1'b0;
        if (flush) begin
            fetch_cs_d = flush_cs;
            fetch_ip_d = flush_ip;
            head_ip_d  = flush_ip;
            drop_d     = pending_q;
        end else begin
            if (rd)  fetch_ip_d = fetch_ip_q + 16'd1;
            if (pop) head_ip_d  = head_ip_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            head_ip_q  <= RESET_IP;
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_cs_q <= fetch_cs_d;
            fetch_ip_q <= fetch_ip_d;
            head_ip_q  <= head_ip_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (flush),
        .push_i  (push),
        .data_i  (i_data),
        .pop_i   (pop),
        .head_o  (q_data),
        .count_o (count)
    );

    assign address = ADDR_W'(linear(fetch_cs_q, fetch_ip_q));
    assign q_valid = (count != '0);
    assign q_ip    = head_ip_q;
    assign q_count = count;

endmodule
